// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and ALU result bundle for alu_arbiter.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_NOR = 3'd3;
  localparam logic [2:0] ALU_ADD = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_SLL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] f;
    logic        zf;
    logic        of;
  } alu_res_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// 32-bit combinational ALU: and/or/xor/nor/add/sub/slt(unsigned)/sll.
// Latency: none (pure combinational). Backpressure: not applicable.
// Flags: zf when f==0, of is signed overflow of add/sub only.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output alu_res_t    res
);

  logic [31:0] sum;
  logic [31:0] diff;

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    res    = '0;
    case (op)
      ALU_AND: res.f = a & b;
      ALU_OR:  res.f = a | b;
      ALU_XOR: res.f = a ^ b;
      ALU_NOR: res.f = ~(a | b);
      ALU_ADD: begin
        res.f  = sum;
        res.of = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        res.f  = diff;
        res.of = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_SLT: res.f = {31'd0, (a < b)};
      ALU_SLL: res.f = a << b[4:0];
      default: res.f = '0;
    endcase
    res.zf = (res.f == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end; ALU_ARB_RR_EN selects round-robin, else requester 0 has fixed priority.
// Latency: accept in cycle N -> RSP_VALID from cycle N+2; one op per 3 cycles at best.
// Backpressure: result held stable in HOLD until RSP_READY; no new accept until then.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int OPCNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               REQ0_VALID,
  output logic               REQ0_READY,
  input  logic [2:0]         REQ0_OP,
  input  logic [31:0]        REQ0_A,
  input  logic [31:0]        REQ0_B,
  input  logic               REQ1_VALID,
  output logic               REQ1_READY,
  input  logic [2:0]         REQ1_OP,
  input  logic [31:0]        REQ1_A,
  input  logic [31:0]        REQ1_B,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic               RSP_ID,
  output logic [31:0]        RSP_F,
  output logic               RSP_ZF,
  output logic               RSP_OF,
  output logic [OPCNT_W-1:0] OP_CNT
);

  state_t      state;
  state_t      state_nxt;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        rsp_hs;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        id_q;
  alu_res_t    alu_res;

`ifdef ALU_ARB_RR_EN
  // last holds the index of the most recently granted requester
  logic last;

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (accept)
      last <= REQ1_READY;
  end

  assign grant0 = REQ0_VALID & (~REQ1_VALID | last);
  assign grant1 = REQ1_VALID & (~REQ0_VALID | ~last);
`else
  assign grant0 = REQ0_VALID;
  assign grant1 = REQ1_VALID & ~REQ0_VALID;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    case (state)
      IDLE: begin
        // readies are combinational, so keep them quiet while reset is asserted
        if (!rst) begin
          REQ0_READY = grant0;
          REQ1_READY = grant1;
          if (grant0 || grant1)
            state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = HOLD;
      HOLD:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = REQ0_READY | REQ1_READY;
  assign rsp_hs = (state == HOLD) & RSP_VALID & RSP_READY;

  alu_arbiter_alu u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_F     <= '0;
      RSP_ZF    <= 1'b0;
      RSP_OF    <= 1'b0;
      OP_CNT    <= '0;
    end else begin
      if (accept) begin
        op_q <= REQ1_READY ? REQ1_OP : REQ0_OP;
        a_q  <= REQ1_READY ? REQ1_A  : REQ0_A;
        b_q  <= REQ1_READY ? REQ1_B  : REQ0_B;
        id_q <= REQ1_READY;
      end
      if (state == EXEC) begin
        RSP_VALID <= 1'b1;
        RSP_ID    <= id_q;
        RSP_F     <= alu_res.f;
        RSP_ZF    <= alu_res.zf;
        RSP_OF    <= alu_res.of;
      end else if (rsp_hs) begin
        RSP_VALID <= 1'b0;
        OP_CNT    <= OP_CNT + OPCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed corner cases plus randomized ops against a behavioural model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [2:0]    REQ0_OP, REQ1_OP;
  logic [31:0]   REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic          RSP_VALID, RSP_READY, RSP_ID, RSP_ZF, RSP_OF;
  logic [31:0]   RSP_F;
  logic [CW-1:0] OP_CNT;

  int checks = 0;
  int errors = 0;
  int mdl_cnt = 0;
  bit mdl_last = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter #(.OPCNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_F(RSP_F),
    .RSP_ZF(RSP_ZF), .RSP_OF(RSP_OF), .OP_CNT(OP_CNT)
  );

  function automatic int mdl_grant(bit v0, bit v1);
    if (!v0 && !v1) return -1;
`ifdef ALU_ARB_RR_EN
    if (v0 && v1) return mdl_last ? 0 : 1;
`else
    if (v0 && v1) return 0;
`endif
    return v0 ? 0 : 1;
  endfunction

  function automatic void mdl_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] f, output logic zf, output logic of);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    of = 1'b0;
    r  = 0;
    case (op)
      ALU_AND: f = a & b;
      ALU_OR:  f = a | b;
      ALU_XOR: f = a ^ b;
      ALU_NOR: f = ~(a | b);
      ALU_ADD: begin r = sa + sb; f = 32'(r); of = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      ALU_SUB: begin r = sa - sb; f = 32'(r); of = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      ALU_SLT: f = (a < b) ? 32'd1 : 32'd0;
      default: f = a << b[4:0];
    endcase
    zf = (f == 32'd0);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_cnt = 0;
    mdl_last = 1'b1;
  endtask

  // Presents one request (from an IDLE sample point), captures the response, stalls, then handshakes.
  task automatic txn(input bit v0, input bit v1, input logic [2:0] op0, input logic [2:0] op1,
                     input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] a1, input logic [31:0] b1,
                     input int stall, output int gid, output int lat, output logic [31:0] f,
                     output logic zf, output logic of, output logic id, output bit steady);
    gid = -1; lat = 0; f = '0; zf = 1'b0; of = 1'b0; id = 1'b0; steady = 1'b1;
    REQ0_VALID = v0; REQ0_OP = op0; REQ0_A = a0; REQ0_B = b0;
    REQ1_VALID = v1; REQ1_OP = op1; REQ1_A = a1; REQ1_B = b1;
    RSP_READY = 1'b0;
    for (int i = 0; i < 8 && gid < 0; i++) begin
      #1;
      if (REQ0_READY && REQ1_READY) steady = 1'b0;
      if (REQ0_READY) gid = 0;
      else if (REQ1_READY) gid = 1;
      @(posedge clk); #1;
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    if (gid < 0) return;
    lat = 1;
    while (!RSP_VALID && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    f = RSP_F; zf = RSP_ZF; of = RSP_OF; id = RSP_ID;
    for (int k = 0; k < stall; k++) begin
      REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
      REQ0_OP = 3'($urandom); REQ0_A = $urandom; REQ1_A = $urandom;
      #1;
      if (REQ0_READY || REQ1_READY || RSP_F !== f || RSP_ZF !== zf || RSP_OF !== of ||
          RSP_ID !== id || RSP_VALID !== 1'b1) steady = 1'b0;
      @(posedge clk); #1;
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(posedge clk); #1;
    RSP_READY = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; RSP_READY = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", REQ0_READY, REQ1_READY); end
    checks++; if (RSP_VALID !== 1'b0 || RSP_ID !== 1'b0) begin errors++; $display("FAIL reset_valid_id got %b %b exp 0 0", RSP_VALID, RSP_ID); end
    checks++; if (RSP_F !== 32'd0 || RSP_ZF !== 1'b0 || RSP_OF !== 1'b0) begin errors++; $display("FAIL reset_f got %h %b %b exp 0", RSP_F, RSP_ZF, RSP_OF); end
    checks++; if (OP_CNT !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", OP_CNT); end
    rst = 1'b0; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RSP_READY = 1'b0;
    mdl_cnt = 0; mdl_last = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    int gid, lat; logic [31:0] f; logic zf, of, id; bit st;
    txn(1'b1, 1'b0, ALU_ADD, ALU_AND, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 0, gid, lat, f, zf, of, id, st);
    mdl_last = 1'b0; mdl_cnt = (mdl_cnt + 1) % (1 << CW);
    checks++; if (gid != 0 || lat != 2) begin errors++; $display("FAIL add_grant_lat got %0d %0d exp 0 2", gid, lat); end
    checks++; if (f !== 32'h8000_0000 || of !== 1'b1 || zf !== 1'b0 || id !== 1'b0) begin errors++; $display("FAIL add_ovf got %h of%b zf%b id%b exp 80000000 1 0 0", f, of, zf, id); end
    checks++; if (int'(OP_CNT) != mdl_cnt || RSP_VALID !== 1'b0) begin errors++; $display("FAIL add_cnt got %0d v%b exp %0d v0", OP_CNT, RSP_VALID, mdl_cnt); end
  endtask

  task automatic test_sub_zero();
    int gid, lat; logic [31:0] f; logic zf, of, id; bit st;
    txn(1'b0, 1'b1, ALU_AND, ALU_SUB, 32'h0, 32'h0, 32'd3, 32'd3, 0, gid, lat, f, zf, of, id, st);
    mdl_last = 1'b1; mdl_cnt = (mdl_cnt + 1) % (1 << CW);
    checks++; if (gid != 1 || lat != 2) begin errors++; $display("FAIL sub_grant_lat got %0d %0d exp 1 2", gid, lat); end
    checks++; if (f !== 32'd0 || zf !== 1'b1 || of !== 1'b0 || id !== 1'b1) begin errors++; $display("FAIL sub_zero got %h zf%b of%b id%b exp 0 1 0 1", f, zf, of, id); end
  endtask

  task automatic test_back_to_back();
    int acc_id[$]; int acc_cyc[$]; int rsp_ids[$]; bit both = 1'b0; int e;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; RSP_READY = 1'b1;
    REQ0_OP = ALU_OR; REQ0_A = 32'h1; REQ0_B = 32'h2;
    REQ1_OP = ALU_XOR; REQ1_A = 32'h5; REQ1_B = 32'h3;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (REQ0_READY && REQ1_READY) both = 1'b1;
      if (REQ0_READY || REQ1_READY) begin acc_id.push_back(REQ1_READY ? 1 : 0); acc_cyc.push_back(c); end
      if (RSP_VALID && RSP_READY) rsp_ids.push_back(RSP_ID ? 1 : 0);
      @(posedge clk); #1;
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RSP_READY = 1'b0;
    checks++; if (both) begin errors++; $display("FAIL b2b_both_ready got 1 exp 0"); end
    checks++; if (acc_id.size() != 4 || rsp_ids.size() != 4) begin errors++; $display("FAIL b2b_count got %0d %0d exp 4 4", acc_id.size(), rsp_ids.size()); end
    for (int k = 0; k < 4 && k < acc_id.size() && k < rsp_ids.size(); k++) begin
      e = mdl_grant(1'b1, 1'b1);
      mdl_last = e[0];
      mdl_cnt = (mdl_cnt + 1) % (1 << CW);
      checks++; if (acc_id[k] != e || rsp_ids[k] != e || acc_cyc[k] != 3 * k) begin errors++; $display("FAIL b2b_op%0d got id %0d rsp %0d cyc %0d exp %0d %0d", k, acc_id[k], rsp_ids[k], acc_cyc[k], e, 3 * k); end
    end
    checks++; if (int'(OP_CNT) != mdl_cnt || RSP_VALID !== 1'b0) begin errors++; $display("FAIL b2b_cnt got %0d v%b exp %0d v0", OP_CNT, RSP_VALID, mdl_cnt); end
  endtask

  task automatic test_hold_stall();
    int gid, lat; logic [31:0] f; logic zf, of, id; bit st;
    txn(1'b1, 1'b0, ALU_XOR, ALU_AND, 32'hF0F0_1234, 32'h0FF0_4321, 32'h0, 32'h0, 5, gid, lat, f, zf, of, id, st);
    mdl_last = 1'b0; mdl_cnt = (mdl_cnt + 1) % (1 << CW);
    checks++; if (!st) begin errors++; $display("FAIL hold_stable got unstable exp stable"); end
    checks++; if (f !== 32'hFF00_5115 || id !== 1'b0) begin errors++; $display("FAIL hold_f got %h id%b exp ff005115 0", f, id); end
    checks++; if (int'(OP_CNT) != mdl_cnt || RSP_VALID !== 1'b0) begin errors++; $display("FAIL hold_cnt got %0d v%b exp %0d v0", OP_CNT, RSP_VALID, mdl_cnt); end
    @(posedge clk); #1;
    checks++; if (RSP_VALID !== 1'b0 || int'(OP_CNT) != mdl_cnt) begin errors++; $display("FAIL hold_single_hs got v%b cnt %0d exp v0 %0d", RSP_VALID, OP_CNT, mdl_cnt); end
  endtask

  task automatic test_rst_exec();
    int gid, lat; logic [31:0] f; logic zf, of, id; bit st;
    do_reset();
    REQ0_VALID = 1'b1; REQ0_OP = ALU_ADD; REQ0_A = 32'd1; REQ0_B = 32'd2; RSP_READY = 1'b1;
    #1;
    checks++; if (REQ0_READY !== 1'b1) begin errors++; $display("FAIL rst_exec_accept got %b exp 1", REQ0_READY); end
    @(posedge clk); #1;
    REQ0_VALID = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mdl_cnt = 0; mdl_last = 1'b1;
    checks++; if (RSP_VALID !== 1'b0 || int'(OP_CNT) != mdl_cnt) begin errors++; $display("FAIL rst_exec_clear got v%b cnt %0d exp v0 %0d", RSP_VALID, OP_CNT, mdl_cnt); end
    @(posedge clk); #1;
    checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL rst_exec_discard got v%b exp v0", RSP_VALID); end
    RSP_READY = 1'b0;
    txn(1'b1, 1'b0, ALU_AND, ALU_OR, 32'h1234_5678, 32'h3333_2222, 32'h0, 32'h0, 0, gid, lat, f, zf, of, id, st);
    mdl_last = 1'b0; mdl_cnt = (mdl_cnt + 1) % (1 << CW);
    checks++; if (f !== 32'h1230_0220 || id !== 1'b0 || lat != 2) begin errors++; $display("FAIL rst_exec_fresh got %h id%b lat %0d exp 12300220 0 2", f, id, lat); end
  endtask

  task automatic test_opcnt_wrap();
    int gid, lat; logic [31:0] f; logic zf, of, id; bit st;
    int exp_seq[4] = '{1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      txn(1'b1, 1'b0, ALU_OR, ALU_AND, 32'(k), 32'h10, 32'h0, 32'h0, k % 2, gid, lat, f, zf, of, id, st);
      mdl_last = 1'b0; mdl_cnt = (mdl_cnt + 1) % (1 << CW);
      checks++; if (int'(OP_CNT) != exp_seq[k]) begin errors++; $display("FAIL wrap_%0d got %0d exp %0d", k, OP_CNT, exp_seq[k]); end
    end
  endtask

  task automatic test_random();
    int gid, lat, eg, stall; logic [31:0] f; logic zf, of, id; bit st;
    logic [2:0] op0, op1; logic [31:0] a0, b0, a1, b1, ef; logic ez, eo; logic [1:0] pat;
    for (int n = 0; n < 24; n++) begin
      pat = 2'($urandom_range(1, 3));
      op0 = 3'($urandom); op1 = 3'($urandom);
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      stall = $urandom_range(0, 3);
      eg = mdl_grant(pat[0], pat[1]);
      if (eg == 1) mdl_alu(op1, a1, b1, ef, ez, eo);
      else mdl_alu(op0, a0, b0, ef, ez, eo);
      txn(pat[0], pat[1], op0, op1, a0, b0, a1, b1, stall, gid, lat, f, zf, of, id, st);
      mdl_last = eg[0]; mdl_cnt = (mdl_cnt + 1) % (1 << CW);
      checks++; if (gid != eg || int'(id) != eg || lat != 2) begin errors++; $display("FAIL rnd%0d_grant got %0d id%b lat %0d exp %0d 2", n, gid, id, lat, eg); end
      checks++; if (f !== ef || zf !== ez || of !== eo) begin errors++; $display("FAIL rnd%0d_alu op %0d got %h z%b o%b exp %h z%b o%b", n, (eg == 1) ? op1 : op0, f, zf, of, ef, ez, eo); end
      checks++; if (!st || int'(OP_CNT) != mdl_cnt || RSP_VALID !== 1'b0) begin errors++; $display("FAIL rnd%0d_hold st%b cnt %0d v%b exp 1 %0d 0", n, st, OP_CNT, RSP_VALID, mdl_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; RSP_READY = 1'b0;
    REQ0_VALID = 1'b0; REQ0_OP = '0; REQ0_A = '0; REQ0_B = '0;
    REQ1_VALID = 1'b0; REQ1_OP = '0; REQ1_A = '0; REQ1_B = '0;
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_back_to_back();
    test_hold_stall();
    test_rst_exec();
    test_opcnt_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
